// File: rtl/dp_fork_scheduler.sv
// Fork-token scheduler for the dining-philosophers FSM network.
// Optional starvation monitor enabled by defining DP_STARVE_MON_EN.
module dp_fork_scheduler #(
  parameter int N_PHIL   = 5,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_PHIL-1:0] req_eat,
  input  logic [N_PHIL-1:0] req_done,
  output logic [N_PHIL-1:0] fire_take,
  output logic [N_PHIL-1:0] fire_release,
  output logic [N_PHIL-1:0] eating,
  output logic [N_PHIL-1:0] fork_busy
`ifdef DP_STARVE_MON_EN
  ,
  output logic [N_PHIL-1:0] starve
`endif
);

  localparam int RR_W = $clog2(N_PHIL);

  if (N_PHIL < 2 || (1 << WAIT_W) <= MAX_WAIT) begin : g_bad_cfg
    $error("dp_fork_scheduler: bad parameters");
  end

  typedef enum logic [1:0] {
    THINK = 2'd0,
    WAIT  = 2'd1,
    EAT   = 2'd2
  } ph_t;

  ph_t               st_q [N_PHIL];
  ph_t               st_d [N_PHIL];
  logic [RR_W-1:0]   rr_q;
  logic [RR_W-1:0]   rr_d;
  logic [N_PHIL-1:0] cand;
  logic [N_PHIL-1:0] grant;
  logic [N_PHIL-1:0] done;
  logic [N_PHIL-1:0] take_q;
  logic [N_PHIL-1:0] rel_q;
  logic [2*N_PHIL-1:0] cand_rot;
  logic [2*N_PHIL-1:0] gnt_rot;
  logic [N_PHIL-1:0] hit;
  logic              found;
  int                nxt;

  assign fire_take    = take_q;
  assign fire_release = rel_q;

  // Eating and fork ownership follow directly from registered states.
  always_comb begin
    eating    = '0;
    fork_busy = '0;
    cand      = '0;
    for (int i = 0; i < N_PHIL; i++) begin
      eating[i] = (st_q[i] == EAT);
    end
    for (int j = 0; j < N_PHIL; j++) begin
      fork_busy[j] = eating[j] | eating[(j + N_PHIL - 1) % N_PHIL];
    end
    for (int i = 0; i < N_PHIL; i++) begin
      cand[i] = (st_q[i] == WAIT) && !fork_busy[i]
                && !fork_busy[(i + 1) % N_PHIL];
    end
  end

  // Round-robin pick: rotate candidates by rr, take lowest, rotate back.
  always_comb begin
    cand_rot = {cand, cand} >> rr_q;
    hit      = '0;
    found    = 1'b0;
    nxt      = 0;
    rr_d     = rr_q;
    for (int k = 0; k < N_PHIL; k++) begin
      if (!found && cand_rot[k]) begin
        found  = 1'b1;
        hit[k] = 1'b1;
        nxt    = int'(rr_q) + k + 1;
      end
    end
    if (nxt >= N_PHIL) begin
      nxt = nxt - N_PHIL;
    end
    if (found) begin
      rr_d = RR_W'(nxt);
    end
    gnt_rot = {{N_PHIL{1'b0}}, hit} << rr_q;
    grant   = gnt_rot[N_PHIL-1:0] | gnt_rot[2*N_PHIL-1:N_PHIL];
  end

  // Per-philosopher THINK/WAIT/EAT next state.
  always_comb begin
    done = '0;
    for (int i = 0; i < N_PHIL; i++) begin
      st_d[i] = st_q[i];
      unique case (st_q[i])
        THINK: if (req_eat[i]) st_d[i] = WAIT;
        WAIT:  if (grant[i]) st_d[i] = EAT;
        EAT: begin
          if (req_done[i]) begin
            st_d[i] = THINK;
            done[i] = 1'b1;
          end
        end
        default: st_d[i] = THINK;
      endcase
    end
  end

  // State, pointer and strobe registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_PHIL; i++) begin
        st_q[i] <= THINK;
      end
      rr_q   <= '0;
      take_q <= '0;
      rel_q  <= '0;
    end else begin
      for (int i = 0; i < N_PHIL; i++) begin
        st_q[i] <= st_d[i];
      end
      rr_q   <= rr_d;
      take_q <= grant;
      rel_q  <= done;
    end
  end

`ifdef DP_STARVE_MON_EN
  logic [WAIT_W-1:0] cnt_q [N_PHIL];
  logic [N_PHIL-1:0] starve_q;

  assign starve = starve_q;

  // Saturating wait counters; starve flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_PHIL; i++) begin
        cnt_q[i] <= '0;
      end
      starve_q <= '0;
    end else begin
      for (int i = 0; i < N_PHIL; i++) begin
        if (st_q[i] == THINK && req_eat[i]) begin
          cnt_q[i] <= '0;
        end else if (st_q[i] == WAIT && cnt_q[i] != '1) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
        if (st_q[i] == WAIT && cnt_q[i] >= WAIT_W'(MAX_WAIT - 1)) begin
          starve_q[i] <= 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_dp_fork_scheduler.sv
// Directed bench for dp_fork_scheduler.
// Covers grant latency, fork conflicts, fairness and reset.
module tb_dp_fork_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] req_eat;
  logic [4:0] req_done;
  logic [4:0] fire_take;
  logic [4:0] fire_release;
  logic [4:0] eating;
  logic [4:0] fork_busy;
`ifdef DP_STARVE_MON_EN
  logic [4:0] starve;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dp_fork_scheduler #(
    .N_PHIL(5),
    .MAX_WAIT(15),
    .WAIT_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_eat(req_eat),
    .req_done(req_done),
    .fire_take(fire_take),
    .fire_release(fire_release),
    .eating(eating),
    .fork_busy(fork_busy)
`ifdef DP_STARVE_MON_EN
    ,
    .starve(starve)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] obs,
                     input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    req_eat  = '0;
    req_done = '0;
    do_reset();
    chk("rst_take", fire_take, 5'b00000);
    chk("rst_rel", fire_release, 5'b00000);
    chk("rst_eat", eating, 5'b00000);
    chk("rst_fork", fork_busy, 5'b00000);

    // single philosopher: two-edge take, one-edge release
    req_eat = 5'b00001;
    step();
    chk("t1_wait_take", fire_take, 5'b00000);
    step();
    chk("t1_take", fire_take, 5'b00001);
    chk("t1_eat", eating, 5'b00001);
    chk("t1_fork", fork_busy, 5'b00011);
    req_eat = '0;
    step();
    chk("t1_take_pulse", fire_take, 5'b00000);
    chk("t1_eat_hold", eating, 5'b00001);
    req_done = 5'b00001;
    step();
    chk("t1_rel", fire_release, 5'b00001);
    chk("t1_fork_free", fork_busy, 5'b00000);
    chk("t1_eat_off", eating, 5'b00000);
    req_done = '0;
    step();
    chk("t1_rel_pulse", fire_release, 5'b00000);

    // non-neighbours: one grant per cycle
    do_reset();
    req_eat = 5'b00101;
    step();
    step();
    chk("t2_take0", fire_take, 5'b00001);
    step();
    chk("t2_take2", fire_take, 5'b00100);
    chk("t2_eat", eating, 5'b00101);
    chk("t2_fork", fork_busy, 5'b01111);
    req_eat  = '0;
    req_done = 5'b00101;
    step();
    chk("t2_rel", fire_release, 5'b00101);
    chk("t2_fork_free", fork_busy, 5'b00000);
    req_done = '0;

    // neighbours: 1 waits for fork 1
    do_reset();
    req_eat = 5'b00011;
    step();
    step();
    chk("t3_take0", fire_take, 5'b00001);
    req_eat = '0;
    step();
    chk("t3_blocked", fire_take, 5'b00000);
    req_done = 5'b00001;
    step();
    chk("t3_rel0", fire_release, 5'b00001);
    chk("t3_no_bypass", fire_take, 5'b00000);
    req_done = '0;
    step();
    chk("t3_take1", fire_take, 5'b00010);
    chk("t3_eat1", eating, 5'b00010);
    chk("t3_fork1", fork_busy, 5'b00110);

    // fairness between 0 and 4 sharing fork 0
    do_reset();
    req_eat = 5'b10001;
    for (int r = 0; r < 20; r++) begin
      for (int c = 0; c < 8 && fire_take == 5'b00000; c++) begin
        step();
      end
      chk($sformatf("t4_round%0d", r), fire_take,
          (r % 2 == 0) ? 5'b00001 : 5'b10000);
      req_done = fire_take;
      step();
      req_done = '0;
    end
    req_eat = '0;

    // reset while 3 eats; pending request of 2 is lost
    do_reset();
    req_eat = 5'b01000;
    step();
    step();
    chk("t5_take3", fire_take, 5'b01000);
    req_eat = 5'b00100;
    step();
    chk("t5_2_blocked", fire_take, 5'b00000);
    reset = 1'b0;
    req_eat = '0;
    step();
    chk("t5_eat_clr", eating, 5'b00000);
    chk("t5_fork_clr", fork_busy, 5'b00000);
    chk("t5_no_rel", fire_release, 5'b00000);
    reset = 1'b1;
    step();
    step();
    chk("t5_lost", fire_take, 5'b00000);
    req_eat = 5'b00100;
    step();
    step();
    chk("t5_resample", fire_take, 5'b00100);
    req_eat = '0;

`ifdef DP_STARVE_MON_EN
    // starvation: 1 waits behind a never-releasing 0
    do_reset();
    chk("t6_rst", starve, 5'b00000);
    req_eat = 5'b00001;
    step();
    step();
    chk("t6_take0", fire_take, 5'b00001);
    req_eat = 5'b00010;
    step();
    for (int c = 0; c < 14; c++) begin
      step();
    end
    chk("t6_before", starve, 5'b00000);
    step();
    chk("t6_set", starve, 5'b00010);
    req_eat  = '0;
    req_done = 5'b00001;
    step();
    req_done = '0;
    step();
    chk("t6_take1", fire_take, 5'b00010);
    chk("t6_sticky", starve, 5'b00010);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
